// File: rtl/radar_scan_sequencer_pkg.sv
// radar_pkg: shared types and constants for the radar scan sequencer.
//   radar_state_e      - scan FSM state encoding
//   CM_MUL / CM_SHIFT  - fixed-point echo-width to centimetre scale (10739 / 2^24)
//   CM_SAT             - largest reportable distance, also the timeout value
//   N_SECTORS_DEFAULT  - default number of sectors per sweep
//   ECHO_CNT_W         - width of the echo width counter
package radar_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SETTLE    = 3'd1,
        S_TRIG      = 3'd2,
        S_WAIT_RISE = 3'd3,
        S_MEASURE   = 3'd4,
        S_RECOVER   = 3'd5,
        S_STEP      = 3'd6
    } radar_state_e;

    localparam int CM_MUL            = 10739;
    localparam int CM_SHIFT          = 24;
    localparam int CM_SAT            = 127;
    localparam int N_SECTORS_DEFAULT = 7;
    localparam int ECHO_CNT_W        = 18;

endpackage

// File: rtl/radar_scan_sequencer_if.sv
// radar_scan_if: sensor and sample signals of the radar scan sequencer.
//   en, ech                       - control level and raw echo into the sequencer
//   tk, sector, dir, busy         - trigger pin, servo command and activity flag
//   sample_valid/_sector/_cm/_timeout - published distance sample
// Handshake: sample_valid is a one-cycle strobe with no ready; the consumer
// must take the sample in the cycle it is high. sample_sector/_cm/_timeout
// stay stable from one strobe until the next, so late readers see the last
// published value.
interface radar_scan_if;

    logic       en;
    logic       ech;
    logic       tk;
    logic [2:0] sector;
    logic       dir;
    logic       busy;
    logic       sample_valid;
    logic [2:0] sample_sector;
    logic [6:0] sample_cm;
    logic       sample_timeout;

    // master drives the sequencer (bench / system), slave is the sequencer
    modport master (
        output en, ech,
        input  tk, sector, dir, busy,
        input  sample_valid, sample_sector, sample_cm, sample_timeout
    );

    modport slave (
        input  en, ech,
        output tk, sector, dir, busy,
        output sample_valid, sample_sector, sample_cm, sample_timeout
    );

endinterface

// File: rtl/radar_scan_sequencer_echo_timer.sv
// echo_timer: synchronises the raw echo pin and measures its high time.
//   clk, rst_n   - clock, asynchronous active-low reset
//   ech_i        - raw asynchronous echo pin
//   start_i      - load the counter with 1 (the rise cycle itself counts)
//   count_en_i   - count synchronised-high cycles while set
//   level_o      - synchronised echo level
//   rise_o/fall_o - one-cycle edge flags of the synchronised echo
//   count_o      - echo width in cycles, saturating at ECHO_MAX_CYC
//   overflow_o   - count has reached ECHO_MAX_CYC
module echo_timer
    import radar_pkg::*;
#(
    parameter int ECHO_MAX_CYC = 198400
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ech_i,
    input  logic                  start_i,
    input  logic                  count_en_i,
    output logic                  level_o,
    output logic                  rise_o,
    output logic                  fall_o,
    output logic [ECHO_CNT_W-1:0] count_o,
    output logic                  overflow_o
);

    logic                  sync1_q, sync2_q, prev_q;
    logic [ECHO_CNT_W-1:0] count_q, count_d;

    // Both edges pass through the same two flops, so the width is preserved.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            count_q <= '0;
        end else begin
            sync1_q <= ech_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            count_q <= count_d;
        end
    end

    assign level_o    = sync2_q;
    assign rise_o     = sync2_q & ~prev_q;
    assign fall_o     = ~sync2_q & prev_q;
    assign overflow_o = (count_q >= ECHO_CNT_W'(ECHO_MAX_CYC));
    assign count_o    = count_q;

    always_comb begin
        count_d = count_q;
        if (start_i) begin
            count_d = ECHO_CNT_W'(1);
        end else if (count_en_i && sync2_q && !overflow_o) begin
            count_d = count_q + ECHO_CNT_W'(1);
        end
    end

endmodule

// File: rtl/radar_scan_sequencer.sv
// radar_scan_sequencer: ping-pong sector sweep with settle, ping, echo
// measurement and recovery, publishing one distance sample per sector.
//   clk, rst_n   - 27 MHz clock, asynchronous active-low reset
//   bus          - radar_scan_if slave: en/ech in; tk, sector, dir, busy and
//                  the sample_* outputs out
//   dbg_state_o  - current FSM state for observation
// Assumes N_SECTORS >= 2 so the sweep has two distinct endpoints.
module radar_scan_sequencer
    import radar_pkg::*;
#(
    parameter int N_SECTORS    = N_SECTORS_DEFAULT,
    parameter int SETTLE_CYC   = 2700000,
    parameter int TRIG_CYC     = 270,
    parameter int RISE_MAX_CYC = 27000,
    parameter int ECHO_MAX_CYC = 198400,
    parameter int RECOVER_CYC  = 1620000
) (
    input  logic         clk,
    input  logic         rst_n,
    radar_scan_if.slave  bus,
    output radar_state_e dbg_state_o
);

    localparam logic [2:0]  LAST_SEC     = 3'(N_SECTORS - 1);
    localparam logic [31:0] SETTLE_LAST  = 32'(SETTLE_CYC - 1);
    localparam logic [31:0] TRIG_LAST    = 32'(TRIG_CYC - 1);
    localparam logic [31:0] RISE_LAST    = 32'(RISE_MAX_CYC - 1);
    localparam logic [31:0] RECOVER_LAST = 32'(RECOVER_CYC - 1);

    radar_state_e state_q, state_d;
    logic [31:0]  cnt_q, cnt_d;
    logic [2:0]   sector_q, sector_d;
    logic         dir_q, dir_d;
    logic         tk_q, tk_d;
    logic         sv_q, sv_d;
    logic [2:0]   ss_q, ss_d;
    logic [6:0]   cm_q, cm_d;
    logic         to_q, to_d;

    logic                  echo_start, echo_count_en;
    logic                  echo_level, echo_rise, echo_fall, echo_ovf;
    logic [ECHO_CNT_W-1:0] echo_count;

    echo_timer #(
        .ECHO_MAX_CYC (ECHO_MAX_CYC)
    ) u_echo_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .ech_i      (bus.ech),
        .start_i    (echo_start),
        .count_en_i (echo_count_en),
        .level_o    (echo_level),
        .rise_o     (echo_rise),
        .fall_o     (echo_fall),
        .count_o    (echo_count),
        .overflow_o (echo_ovf)
    );

    // cm = min(CM_SAT, (count * CM_MUL) >> CM_SHIFT), full 36-bit product
    logic [35:0] cm_prod, cm_scaled;
    logic [6:0]  cm_conv;
    assign cm_prod   = {{(36 - ECHO_CNT_W){1'b0}}, echo_count} * 36'(CM_MUL);
    assign cm_scaled = cm_prod >> CM_SHIFT;
    assign cm_conv   = (|cm_scaled[35:7]) ? 7'(CM_SAT) : cm_scaled[6:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            sector_q <= '0;
            dir_q    <= 1'b0;
            tk_q     <= 1'b0;
            sv_q     <= 1'b0;
            ss_q     <= '0;
            cm_q     <= '0;
            to_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sector_q <= sector_d;
            dir_q    <= dir_d;
            tk_q     <= tk_d;
            sv_q     <= sv_d;
            ss_q     <= ss_d;
            cm_q     <= cm_d;
            to_q     <= to_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        sector_d      = sector_q;
        dir_d         = dir_q;
        sv_d          = 1'b0;
        ss_d          = ss_q;
        cm_d          = cm_q;
        to_d          = to_q;
        echo_start    = 1'b0;
        echo_count_en = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.en) begin
                    state_d = S_SETTLE;
                    cnt_d   = '0;
                end
            end
            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = S_TRIG;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            // en is deliberately ignored here so the pulse is never cut short
            S_TRIG: begin
                if (cnt_q == TRIG_LAST) begin
                    state_d = S_WAIT_RISE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            // only an edge seen here counts; a level already high is ignored
            S_WAIT_RISE: begin
                if (echo_rise) begin
                    state_d    = S_MEASURE;
                    echo_start = 1'b1;
                    cnt_d      = '0;
                end else if (cnt_q == RISE_LAST) begin
                    state_d = S_RECOVER;
                    cnt_d   = '0;
                    sv_d    = 1'b1;
                    ss_d    = sector_q;
                    cm_d    = 7'(CM_SAT);
                    to_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_MEASURE: begin
                echo_count_en = 1'b1;
                if (echo_fall) begin
                    state_d = S_RECOVER;
                    cnt_d   = '0;
                    sv_d    = 1'b1;
                    ss_d    = sector_q;
                    cm_d    = cm_conv;
                    to_d    = 1'b0;
                end else if (echo_ovf) begin
                    state_d = S_RECOVER;
                    cnt_d   = '0;
                    sv_d    = 1'b1;
                    ss_d    = sector_q;
                    cm_d    = 7'(CM_SAT);
                    to_d    = 1'b1;
                end
            end
            // quiet time starts only once the echo line has gone low
            S_RECOVER: begin
                if (echo_level) begin
                    cnt_d = '0;
                end else if (cnt_q == RECOVER_LAST) begin
                    state_d = S_STEP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_STEP: begin
                if (!bus.en) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_SETTLE;
                    cnt_d   = '0;
                    // endpoints turn around directly, so they are never repeated
                    if (!dir_q) begin
                        if (sector_q == LAST_SEC) begin
                            dir_d    = 1'b1;
                            sector_d = LAST_SEC - 3'd1;
                        end else begin
                            sector_d = sector_q + 3'd1;
                        end
                    end else begin
                        if (sector_q == 3'd0) begin
                            dir_d    = 1'b0;
                            sector_d = 3'd1;
                        end else begin
                            sector_d = sector_q - 3'd1;
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // registered trigger: high exactly for the cycles spent in TRIG
        tk_d = (state_d == S_TRIG);
    end

    assign bus.tk             = tk_q;
    assign bus.sector         = sector_q;
    assign bus.dir            = dir_q;
    assign bus.busy           = (state_q != S_IDLE);
    assign bus.sample_valid   = sv_q;
    assign bus.sample_sector  = ss_q;
    assign bus.sample_cm      = cm_q;
    assign bus.sample_timeout = to_q;
    assign dbg_state_o        = state_q;

endmodule

// File: tb/tb_radar_scan_sequencer.sv
// tb_radar_scan_sequencer: bench for radar_scan_sequencer with shortened
// timing. A second instance with a small echo limit covers the long-echo
// overflow path inside a short run.
module tb_radar_scan_sequencer;
    import radar_pkg::*;

    localparam int SETTLE_CYC     = 100;
    localparam int TRIG_CYC       = 10;
    localparam int RISE_MAX_CYC   = 500;
    localparam int RECOVER_CYC    = 50;
    localparam int ECHO_MAX_CYC   = 198400;
    localparam int ECHO_MAX_SHORT = 2000;
    localparam int SB_W           = 11;

    logic clk;
    logic rst_n;

    radar_scan_if bus();
    radar_scan_if bus_s();
    radar_state_e dbg_state, dbg_state_s;

    int               n_cmp = 0;
    int               n_err = 0;
    logic [SB_W-1:0]  exp_q[$];
    logic [2:0]       m_sec = 3'd0;
    logic             m_dir = 1'b0;

    radar_scan_sequencer #(
        .N_SECTORS(7), .SETTLE_CYC(SETTLE_CYC), .TRIG_CYC(TRIG_CYC),
        .RISE_MAX_CYC(RISE_MAX_CYC), .ECHO_MAX_CYC(ECHO_MAX_CYC), .RECOVER_CYC(RECOVER_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .dbg_state_o(dbg_state)
    );

    radar_scan_sequencer #(
        .N_SECTORS(7), .SETTLE_CYC(SETTLE_CYC), .TRIG_CYC(TRIG_CYC),
        .RISE_MAX_CYC(RISE_MAX_CYC), .ECHO_MAX_CYC(ECHO_MAX_SHORT), .RECOVER_CYC(RECOVER_CYC)
    ) dut_s (
        .clk(clk), .rst_n(rst_n), .bus(bus_s), .dbg_state_o(dbg_state_s)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #10_000_000;
        $display("FAIL watchdog: got still running expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- models ----------------
    function automatic logic [6:0] model_cm(input int width);
        longint p;
        p = longint'(width) * 64'd10739;
        p = p >>> 24;
        if (p > 127) return 7'd127;
        return 7'(p);
    endfunction

    task automatic model_advance();
        if (!m_dir) begin
            if (m_sec == 3'd6) begin m_dir = 1'b1; m_sec = 3'd5; end
            else m_sec = m_sec + 3'd1;
        end else begin
            if (m_sec == 3'd0) begin m_dir = 1'b0; m_sec = 3'd1; end
            else m_sec = m_sec - 3'd1;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_tk_rise(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (bus.tk) begin ok = 1'b1; break; end
        end
    endtask

    task automatic measure_tk(output int len);
        len = 1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!bus.tk) break;
            len++;
        end
    endtask

    task automatic drive_echo(input int delay, input int width);
        repeat (delay) @(negedge clk);
        bus.ech = 1'b1;
        repeat (width) @(negedge clk);
        bus.ech = 1'b0;
    endtask

    task automatic wait_sample(input int limit, output bit ok, output int n);
        ok = 1'b0;
        n  = 0;
        while (n < limit) begin
            @(negedge clk);
            n++;
            if (bus.sample_valid) begin ok = 1'b1; break; end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [22:0] got;
        rst_n = 1'b0;
        bus.en = 1'b0; bus.ech = 1'b0;
        bus_s.en = 1'b0; bus_s.ech = 1'b0;
        repeat (5) @(negedge clk);
        got = {bus.tk, bus.sector, bus.dir, bus.busy, bus.sample_valid,
               bus.sample_sector, bus.sample_cm, bus.sample_timeout, dbg_state};
        n_cmp++;
        if (got !== 23'd0) begin
            n_err++; $display("FAIL reset_outputs: got %h expected 0", got);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        got = {bus_s.tk, bus_s.sector, bus_s.dir, bus_s.busy, bus_s.sample_valid,
               bus_s.sample_sector, bus_s.sample_cm, bus_s.sample_timeout, dbg_state_s};
        n_cmp++;
        if (got !== 23'd0 || dbg_state !== S_IDLE) begin
            n_err++; $display("FAIL reset_idle_hold: got %h/%0d expected 0/IDLE", got, dbg_state);
        end
    endtask

    task automatic test_nominal();
        bit ok; int len, n;
        logic [SB_W-1:0] exp, got;
        bus.en = 1'b1;
        exp_q.push_back({m_sec, 7'd10, 1'b0});
        wait_tk_rise(ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL nominal_tk_rise: got none expected trigger"); end
        measure_tk(len);
        n_cmp++;
        if (len != TRIG_CYC) begin
            n_err++; $display("FAIL nominal_tk_len: got %0d expected %0d", len, TRIG_CYC);
        end
        drive_echo(20, 15623);
        wait_sample(10, ok, n);
        exp = exp_q.pop_front();
        got = {bus.sample_sector, bus.sample_cm, bus.sample_timeout};
        n_cmp++;
        if (!ok || got !== exp) begin
            n_err++; $display("FAIL nominal_sample: got %h (valid=%0d) expected %h", got, ok, exp);
        end
        n_cmp++;
        if (n != 3) begin n_err++; $display("FAIL nominal_latency: got %0d expected 3", n); end
        @(negedge clk);
        n_cmp++;
        if (bus.sample_valid !== 1'b0 || bus.sample_cm !== 7'd10) begin
            n_err++; $display("FAIL nominal_pulse_hold: got valid=%0d cm=%0d expected valid=0 cm=10",
                              bus.sample_valid, bus.sample_cm);
        end
        model_advance();
    endtask

    task automatic test_sweep();
        bit ok; int len, n, w, d;
        logic [SB_W-1:0] exp, got;
        for (int i = 0; i < 13; i++) begin
            w = $urandom_range(5000, 200);
            d = $urandom_range(60, 5);
            exp_q.push_back({m_sec, model_cm(w), 1'b0});
            wait_tk_rise(ok);
            measure_tk(len);
            drive_echo(d, w);
            wait_sample(10, ok, n);
            exp = exp_q.pop_front();
            got = {bus.sample_sector, bus.sample_cm, bus.sample_timeout};
            n_cmp++;
            if (!ok || got !== exp) begin
                n_err++; $display("FAIL sweep_sample[%0d]: got %h (valid=%0d) expected %h", i, got, ok, exp);
            end
            n_cmp++;
            if (bus.dir !== m_dir || bus.sector !== m_sec) begin
                n_err++; $display("FAIL sweep_dir[%0d]: got dir=%0d sec=%0d expected dir=%0d sec=%0d",
                                  i, bus.dir, bus.sector, m_dir, m_sec);
            end
            model_advance();
        end
    endtask

    task automatic test_no_echo();
        bit ok; int len, n;
        logic [SB_W-1:0] exp, got;
        exp_q.push_back({m_sec, 7'd127, 1'b1});
        wait_tk_rise(ok);
        measure_tk(len);
        wait_sample(RISE_MAX_CYC + 20, ok, n);
        exp = exp_q.pop_front();
        got = {bus.sample_sector, bus.sample_cm, bus.sample_timeout};
        n_cmp++;
        if (!ok || got !== exp) begin
            n_err++; $display("FAIL no_echo_sample: got %h (valid=%0d) expected %h", got, ok, exp);
        end
        n_cmp++;
        if (n != RISE_MAX_CYC) begin
            n_err++; $display("FAIL no_echo_delay: got %0d expected %0d", n, RISE_MAX_CYC);
        end
        model_advance();
    endtask

    task automatic test_en_drop();
        bit ok; int len, n, tk_cnt;
        logic [SB_W-1:0] exp, got;
        exp_q.push_back({m_sec, 7'd2, 1'b0});
        wait_tk_rise(ok);
        measure_tk(len);
        repeat (20) @(negedge clk);
        bus.ech = 1'b1;
        repeat (100) @(negedge clk);
        bus.en = 1'b0;
        repeat (3025) @(negedge clk);
        bus.ech = 1'b0;
        wait_sample(10, ok, n);
        exp = exp_q.pop_front();
        got = {bus.sample_sector, bus.sample_cm, bus.sample_timeout};
        n_cmp++;
        if (!ok || got !== exp) begin
            n_err++; $display("FAIL en_drop_sample: got %h (valid=%0d) expected %h", got, ok, exp);
        end
        tk_cnt = 0;
        repeat (300) begin
            @(negedge clk);
            if (bus.tk) tk_cnt++;
        end
        n_cmp++;
        if (dbg_state !== S_IDLE || bus.busy !== 1'b0 || tk_cnt != 0 || bus.sector !== m_sec) begin
            n_err++; $display("FAIL en_drop_idle: got state=%0d busy=%0d tk=%0d sec=%0d expected 0/0/0/%0d",
                              dbg_state, bus.busy, tk_cnt, bus.sector, m_sec);
        end
    endtask

    task automatic test_long_echo();
        bit ok, early_step; int n, n2;
        logic [SB_W-1:0] exp, got;
        bus_s.en = 1'b1;
        exp_q.push_back({3'd0, 7'd127, 1'b1});
        for (int i = 0; i < 2000 && !bus_s.tk; i++) @(negedge clk);
        for (int i = 0; i < 100 && bus_s.tk; i++) @(negedge clk);
        repeat (20) @(negedge clk);
        bus_s.ech = 1'b1;
        ok = 1'b0; n = 0;
        while (n < ECHO_MAX_SHORT + 100) begin
            @(negedge clk);
            n++;
            if (bus_s.sample_valid) begin ok = 1'b1; break; end
        end
        exp = exp_q.pop_front();
        got = {bus_s.sample_sector, bus_s.sample_cm, bus_s.sample_timeout};
        n_cmp++;
        if (!ok || got !== exp) begin
            n_err++; $display("FAIL long_echo_sample: got %h (valid=%0d) expected %h", got, ok, exp);
        end
        n_cmp++;
        if (n < ECHO_MAX_SHORT + 2 || n > ECHO_MAX_SHORT + 4) begin
            n_err++; $display("FAIL long_echo_when: got %0d expected %0d", n, ECHO_MAX_SHORT + 3);
        end
        bus_s.en = 1'b0;
        early_step = 1'b0;
        repeat (2500 - n) begin
            @(negedge clk);
            if (dbg_state_s == S_STEP) early_step = 1'b1;
        end
        bus_s.ech = 1'b0;
        n2 = 0;
        while (n2 < 200) begin
            @(negedge clk);
            n2++;
            if (dbg_state_s == S_STEP) break;
        end
        n_cmp++;
        if (early_step || n2 < 51 || n2 > 53) begin
            n_err++; $display("FAIL long_echo_step: got %0d cycles (early=%0d) expected 52", n2, early_step);
        end
    endtask

    task automatic test_reset_trig();
        bit ok;
        logic [5:0] got;
        bus.en = 1'b1;
        wait_tk_rise(ok);
        repeat (4) @(negedge clk);
        n_cmp++;
        if (!ok || bus.tk !== 1'b1) begin
            n_err++; $display("FAIL reset_trig_pre: got tk=%0d expected 1", bus.tk);
        end
        rst_n = 1'b0;
        #1;
        got = {bus.tk, bus.sector, bus.busy, bus.dir};
        n_cmp++;
        if (got !== 6'd0 || dbg_state !== S_IDLE) begin
            n_err++; $display("FAIL reset_trig_async: got %b state=%0d expected 000000 IDLE", got, dbg_state);
        end
        bus.en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus.tk !== 1'b0 || bus.busy !== 1'b0) begin
            n_err++; $display("FAIL reset_trig_after: got tk=%0d busy=%0d expected 0/0", bus.tk, bus.busy);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_nominal();
        test_sweep();
        test_no_echo();
        test_en_drop();
        test_long_echo();
        test_reset_trig();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
